// File: rtl/multi_cycle_control_pkg.sv
// multi_cycle_control_pkg: states, opcode patterns, instruction classes and mux codes for the LEGv8 multi-cycle controller
package multi_cycle_control_pkg;
  typedef enum logic [3:0] {
    S_FETCH_IDLE, S_FETCH, S_FETCH_DONE, S_DECODE, S_ADDR_LD, S_ADDR_ST, S_LD_MEM, S_LD_WB,
    S_ST_MEM, S_R_EX, S_I_EX, S_ALU_WB, S_CBZ_EX, S_B_EX, S_HALT
  } state_t;
  typedef enum logic [2:0] {OC_ILL, OC_LD, OC_ST, OC_R, OC_I, OC_CBZ, OC_B} opclass_t;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LSL  = 11'b11010011011;
  localparam logic [9:0]  OP_ORRI = 10'b1011001000;
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;
  localparam logic [5:0]  OP_B    = 6'b000101;
  localparam logic [1:0]  ALU_ADD   = 2'b00;
  localparam logic [1:0]  ALU_PASSB = 2'b01;
  localparam logic [1:0]  ALU_FUNCT = 2'b10;
  localparam logic [1:0]  PC_PLUS4  = 2'b00;
  localparam logic [1:0]  PC_BRANCH = 2'b01;
endpackage

// File: rtl/multi_cycle_control_if.sv
// multi_cycle_control_if: controller <-> datapath/memory signals; master is the controller side
interface multi_cycle_control_if #(parameter int CNT_W = 32);
  logic [10:0] Opcode;
  logic Zero, MemReady;
  logic InstrFetch, IRWrite, PCWrite;
  logic [1:0] PCSrc;
  logic Reg2Loc, ALUSrcB;
  logic [1:0] ALUOp;
  logic MemRead, MemWrite, MemToReg, RegWrite, Busy, Trap;
  logic [CNT_W-1:0] RetiredCnt;
  modport master (
    input Opcode, Zero, MemReady,
    output InstrFetch, IRWrite, PCWrite, PCSrc, Reg2Loc, ALUSrcB, ALUOp,
           MemRead, MemWrite, MemToReg, RegWrite, Busy, Trap, RetiredCnt
  );
  modport slave (
    output Opcode, Zero, MemReady,
    input InstrFetch, IRWrite, PCWrite, PCSrc, Reg2Loc, ALUSrcB, ALUOp,
          MemRead, MemWrite, MemToReg, RegWrite, Busy, Trap, RetiredCnt
  );
endinterface

// File: rtl/multi_cycle_control_opclass.sv
// multi_cycle_control_opclass: combinational opcode -> instruction class, shared with trace tooling
module multi_cycle_control_opclass
  import multi_cycle_control_pkg::*;
(
  input  logic [10:0] opcode,
  output opclass_t    opclass
);
  always_comb
    opclass = opcode == OP_LDUR ? OC_LD :
              opcode == OP_STUR ? OC_ST :
              opcode inside {OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_LSL} ? OC_R :
              opcode[10:1] == OP_ORRI ? OC_I :
              opcode[10:3] == OP_CBZ ? OC_CBZ :
              opcode[10:5] == OP_B ? OC_B : OC_ILL;
endmodule

// File: rtl/multi_cycle_control.sv
// multi_cycle_control: Moore FSM sequencing the LEGv8 datapath through fetch/decode/exec/mem/wb
module multi_cycle_control
  import multi_cycle_control_pkg::*;
#(
  parameter int CNT_W    = 32,
  parameter int MEM_TOUT = 15
) (
  input logic CLK,
  input logic Reset,
  multi_cycle_control_if.master bus
);
  localparam int WAIT_W = MEM_TOUT > 1 ? $clog2(MEM_TOUT + 1) : 1;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  opclass_t opclass;
  logic mem_state, timeout, retire;
  multi_cycle_control_opclass u_opclass (.opcode(bus.Opcode), .opclass(opclass));
  assign mem_state = state_q inside {S_FETCH, S_LD_MEM, S_ST_MEM};
  // A ready in the limit cycle completes the access instead of trapping
  assign timeout = MEM_TOUT != 0 && mem_state && !bus.MemReady && wait_q == WAIT_W'(MEM_TOUT - 1);
  assign retire = state_q inside {S_LD_WB, S_ALU_WB, S_CBZ_EX, S_B_EX} ||
                  (state_q == S_ST_MEM && bus.MemReady);
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH_IDLE: state_d = S_FETCH;
      S_FETCH:      state_d = bus.MemReady ? S_FETCH_DONE : S_FETCH;
      S_FETCH_DONE: state_d = S_DECODE;
      S_DECODE:     state_d = opclass == OC_LD  ? S_ADDR_LD :
                              opclass == OC_ST  ? S_ADDR_ST :
                              opclass == OC_R   ? S_R_EX :
                              opclass == OC_I   ? S_I_EX :
                              opclass == OC_CBZ ? S_CBZ_EX :
                              opclass == OC_B   ? S_B_EX : S_HALT;
      S_ADDR_LD:    state_d = S_LD_MEM;
      S_ADDR_ST:    state_d = S_ST_MEM;
      S_LD_MEM:     state_d = bus.MemReady ? S_LD_WB : S_LD_MEM;
      S_ST_MEM:     state_d = bus.MemReady ? S_FETCH : S_ST_MEM;
      S_R_EX, S_I_EX: state_d = S_ALU_WB;
      S_LD_WB, S_ALU_WB, S_CBZ_EX, S_B_EX: state_d = S_FETCH;
      default:      state_d = state_q;
    endcase
    if (timeout) state_d = S_HALT;
    wait_d = (MEM_TOUT != 0 && mem_state && !bus.MemReady) ? wait_q + WAIT_W'(1) : '0;
    cnt_d = retire ? cnt_q + CNT_W'(1) : cnt_q;
  end
  always_ff @(posedge CLK or posedge Reset)
    if (Reset) begin
      state_q <= S_FETCH_IDLE;
      cnt_q <= '0;
      wait_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      wait_q <= wait_d;
    end
  // Only the conditional branch write looks at an input: Zero is produced in CBZ_EX itself
  assign bus.InstrFetch = state_q == S_FETCH;
  assign bus.MemRead    = state_q inside {S_FETCH, S_LD_MEM};
  assign bus.IRWrite    = state_q == S_FETCH_DONE;
  assign bus.PCWrite    = state_q inside {S_FETCH_DONE, S_B_EX} || (state_q == S_CBZ_EX && bus.Zero);
  assign bus.PCSrc      = state_q inside {S_CBZ_EX, S_B_EX} ? PC_BRANCH : PC_PLUS4;
  assign bus.Reg2Loc    = state_q inside {S_ADDR_ST, S_ST_MEM, S_CBZ_EX};
  assign bus.ALUSrcB    = state_q inside {S_ADDR_LD, S_ADDR_ST, S_I_EX};
  assign bus.ALUOp      = state_q inside {S_R_EX, S_I_EX} ? ALU_FUNCT :
                          state_q == S_CBZ_EX ? ALU_PASSB : ALU_ADD;
  assign bus.MemWrite   = state_q == S_ST_MEM;
  assign bus.MemToReg   = state_q == S_LD_WB;
  assign bus.RegWrite   = state_q inside {S_LD_WB, S_ALU_WB};
  assign bus.Busy       = state_q != S_FETCH_IDLE;
  assign bus.Trap       = state_q == S_HALT;
  assign bus.RetiredCnt = cnt_q;
endmodule

// File: tb/tb_multi_cycle_control.sv
// tb_multi_cycle_control: per-cycle vector table through a scoreboard queue, plus timeout and wrap sequences
module tb_multi_cycle_control;
  localparam logic [10:0] OP_ADD  = 11'b10001011000, OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000, OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LSL  = 11'b11010011011, OP_ORRI = 11'b10110010001;
  localparam logic [10:0] OP_CBZ  = 11'b10110100101, OP_B    = 11'b00010110011;
  localparam logic [10:0] OP_LDUR = 11'b11111000010, OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_ILL  = 11'b11111111111, GARB    = 11'b11111111111;
  typedef logic [14:0] out_t;
  // ifetch irw pcw pcsrc r2l asb aluop mr mw m2r rw busy trap
  localparam out_t O_IDLE = 15'b0_0_0_00_0_0_00_0_0_0_0_0_0;
  localparam out_t O_FET  = 15'b1_0_0_00_0_0_00_1_0_0_0_1_0;
  localparam out_t O_FD   = 15'b0_1_1_00_0_0_00_0_0_0_0_1_0;
  localparam out_t O_DEC  = 15'b0_0_0_00_0_0_00_0_0_0_0_1_0;
  localparam out_t O_ALD  = 15'b0_0_0_00_0_1_00_0_0_0_0_1_0;
  localparam out_t O_AST  = 15'b0_0_0_00_1_1_00_0_0_0_0_1_0;
  localparam out_t O_LDM  = 15'b0_0_0_00_0_0_00_1_0_0_0_1_0;
  localparam out_t O_LDWB = 15'b0_0_0_00_0_0_00_0_0_1_1_1_0;
  localparam out_t O_STM  = 15'b0_0_0_00_1_0_00_0_1_0_0_1_0;
  localparam out_t O_REX  = 15'b0_0_0_00_0_0_10_0_0_0_0_1_0;
  localparam out_t O_IEX  = 15'b0_0_0_00_0_1_10_0_0_0_0_1_0;
  localparam out_t O_AWB  = 15'b0_0_0_00_0_0_00_0_0_0_1_1_0;
  localparam out_t O_CBT  = 15'b0_0_1_01_1_0_01_0_0_0_0_1_0;
  localparam out_t O_CBN  = 15'b0_0_0_01_1_0_01_0_0_0_0_1_0;
  localparam out_t O_BEX  = 15'b0_0_1_01_0_0_00_0_0_0_0_1_0;
  localparam out_t O_HALT = 15'b0_0_0_00_0_0_00_0_0_0_0_1_1;
  typedef struct {
    logic rst;
    logic [10:0] op;
    logic z;
    logic rdy;
    out_t exp;
    logic [3:0] cnt;
    string tag;
  } vec_t;
  logic CLK = 1'b0;
  logic Reset = 1'b1;
  vec_t tbl[$];
  vec_t sb[$];
  int applied = 0;
  int miscompares = 0;
  logic [3:0] ec = 4'd0;
  string ph = "reset";
  always #5 CLK = ~CLK;
  multi_cycle_control_if #(.CNT_W(4)) bus ();
  multi_cycle_control #(.CNT_W(4), .MEM_TOUT(15)) dut (.CLK(CLK), .Reset(Reset), .bus(bus));
  task automatic add(input logic rst, input logic [10:0] op, input logic z, input logic rdy, input out_t exp);
    tbl.push_back('{rst, op, z, rdy, exp, ec, ph});
  endtask
  task automatic fetch(input int w);
    repeat (w) add(0, GARB, 1, 0, O_FET);
    add(0, GARB, 1, 1, O_FET);
    add(0, GARB, 1, 1, O_FD);
  endtask
  task automatic alu(input logic [10:0] op, input logic imm, input int w);
    fetch(w);
    add(0, op, 1, 1, O_DEC);
    add(0, GARB, 1, 1, imm ? O_IEX : O_REX);
    add(0, GARB, 1, 1, O_AWB);
    ec++;
  endtask
  task automatic branch(input logic [10:0] op, input logic z, input out_t exp);
    fetch(0);
    add(0, op, 0, 1, O_DEC);
    add(0, GARB, z, 1, exp);
    ec++;
  endtask
  task automatic ldur(input int w);
    fetch(0);
    add(0, OP_LDUR, 1, 1, O_DEC);
    add(0, GARB, 1, 1, O_ALD);
    repeat (w) add(0, GARB, 1, 0, O_LDM);
    add(0, GARB, 1, 1, O_LDM);
    add(0, GARB, 1, 0, O_LDWB);
    ec++;
  endtask
  task automatic stur(input int w);
    fetch(0);
    add(0, OP_STUR, 1, 1, O_DEC);
    add(0, GARB, 1, 1, O_AST);
    repeat (w) add(0, GARB, 1, 0, O_STM);
    add(0, GARB, 1, 1, O_STM);
    ec++;
  endtask
  task automatic do_reset();
    ec = 4'd0;
    add(1, GARB, 1, 1, O_IDLE);
    add(0, GARB, 1, 1, O_IDLE);
  endtask
  task automatic check();
    vec_t e;
    out_t act;
    e = sb.pop_front();
    act = {bus.InstrFetch, bus.IRWrite, bus.PCWrite, bus.PCSrc, bus.Reg2Loc, bus.ALUSrcB, bus.ALUOp,
           bus.MemRead, bus.MemWrite, bus.MemToReg, bus.RegWrite, bus.Busy, bus.Trap};
    applied++;
    if (act !== e.exp) begin
      miscompares++;
      $display("FAIL %s vec %0d outputs: got %b want %b", e.tag, applied, act, e.exp);
    end
    if (bus.RetiredCnt !== e.cnt) begin
      miscompares++;
      $display("FAIL %s vec %0d RetiredCnt: got %0d want %0d", e.tag, applied, bus.RetiredCnt, e.cnt);
    end
  endtask
  task automatic apply(input vec_t v);
    @(negedge CLK);
    Reset = v.rst;
    bus.Opcode = v.op;
    bus.Zero = v.z;
    bus.MemReady = v.rdy;
    sb.push_back(v);
    #1 check();
  endtask
  task automatic run();
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);
    tbl.delete();
  endtask
  initial begin
    bus.Opcode = GARB;
    bus.Zero = 1'b0;
    bus.MemReady = 1'b0;
    ph = "reset";      add(1, GARB, 1, 1, O_IDLE); do_reset();
    ph = "add";        alu(OP_ADD, 0, 0);
    ph = "sub";        alu(OP_SUB, 0, 0);
    ph = "and";        alu(OP_AND, 0, 0);
    ph = "orr";        alu(OP_ORR, 0, 0);
    ph = "lsl";        alu(OP_LSL, 0, 0);
    ph = "orri";       alu(OP_ORRI, 1, 0);
    ph = "b";          branch(OP_B, 0, O_BEX);
    ph = "cbz_taken";  branch(OP_CBZ, 1, O_CBT);
    ph = "cbz_not";    branch(OP_CBZ, 0, O_CBN);
    ph = "stur";       stur(0);
    ph = "stur_wait";  stur(2);
    ph = "ldur";       ldur(0);
    ph = "ldur_wait";  ldur(3);
    ph = "fetch_wait"; alu(OP_ADD, 0, 2);
    ph = "rst_mid_ld";
    fetch(0);
    add(0, OP_LDUR, 1, 1, O_DEC);
    add(0, GARB, 1, 1, O_ALD);
    add(0, GARB, 1, 0, O_LDM);
    add(0, GARB, 1, 0, O_LDM);
    ec = 4'd0;
    add(1, GARB, 1, 1, O_IDLE);
    add(0, GARB, 1, 1, O_IDLE);
    alu(OP_ADD, 0, 0);
    ph = "illegal";
    fetch(0);
    add(0, OP_ILL, 1, 1, O_DEC);
    repeat (20) add(0, OP_ADD, 1, 1, O_HALT);
    ph = "trap_clear"; do_reset();
    run();
    ph = "tout_edge";  alu(OP_ADD, 0, 14);
    ph = "timeout";
    repeat (15) add(0, GARB, 1, 0, O_FET);
    add(0, GARB, 1, 0, O_HALT);
    add(0, GARB, 1, 1, O_HALT);
    do_reset();
    run();
    ph = "wrap";
    repeat (16) alu(OP_ADD, 0, 0);
    add(0, GARB, 1, 0, O_FET);
    run();
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end
endmodule
